// File: rtl/crossbar_seq.sv
// Command sequencer in front of crossbar_top: turns FORM/WRITE/MAC commands into timed line patterns and strobes.
// Optional feature macro: CROSSBAR_SEQ_FORM_LOCK_EN (rejects WRITEs to cells that were never formed).
module crossbar_seq #(
    parameter int SETUP_CYC = 2,
    parameter int FORM_CYC  = 20,
    parameter int WRITE_CYC = 10,
    parameter int MAC_CYC   = 4,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_row,
    input  logic [2:0] cmd_col,
    input  logic       cmd_data,
    input  logic [7:0] cmd_x,
    output logic [7:0] bitline,
    output logic [7:0] wordline,
    output logic [7:0] selectline,
    output logic       wenable,
    output logic       form,
    output logic       mac,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_FORM  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_MAC   = 2'b11;

    // Timer reload is N-1; a zero-length phase still lasts one cycle.
    function automatic logic [CNT_W-1:0] ld_val(input int n);
        return (n <= 1) ? '0 : CNT_W'(n - 1);
    endfunction

    localparam logic [CNT_W-1:0] SETUP_LD = ld_val(SETUP_CYC);
    localparam logic [CNT_W-1:0] FORM_LD  = ld_val(FORM_CYC);
    localparam logic [CNT_W-1:0] WRITE_LD = ld_val(WRITE_CYC);
    localparam logic [CNT_W-1:0] MAC_LD   = ld_val(MAC_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD  = ld_val(HOLD_CYC);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       wl_q, wl_d, bl_q, bl_d, sl_q, sl_d;
    logic             wen_q, wen_d, form_q, form_d, mac_q, mac_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             accept, write_locked;

    assign cmd_ready = (state_q == ST_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

`ifdef CROSSBAR_SEQ_FORM_LOCK_EN
    logic [63:0] formed_q, formed_d;
    logic [2:0]  row_q, row_d, col_q, col_d;

    assign write_locked = (cmd_op == OP_WRITE) && !formed_q[{cmd_row, cmd_col}];

    always_comb begin
        row_d    = accept ? cmd_row : row_q;
        col_d    = accept ? cmd_col : col_q;
        formed_d = formed_q;
        if (state_q == ST_HOLD && state_d == ST_DONE && op_q == OP_FORM)
            formed_d[{row_q, col_q}] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            formed_q <= '0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            formed_q <= formed_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end
`else
    assign write_locked = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        op_d    = op_q;
        wl_d    = wl_q;
        bl_d    = bl_q;
        sl_d    = sl_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = cmd_op;
                    if (cmd_op == OP_NOP) begin
                        state_d = ST_DONE;
                        timer_d = '0;
                    end else if (write_locked) begin
                        state_d = ST_DONE;
                        timer_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_SETUP;
                        timer_d = SETUP_LD;
                        wl_d    = (cmd_op == OP_MAC) ? 8'hFF : (8'b1 << cmd_row);
                        bl_d    = '0;
                        sl_d    = '0;
                        if (cmd_op == OP_MAC)
                            bl_d = cmd_x;
                        else if (cmd_op == OP_WRITE && !cmd_data)
                            sl_d = 8'b1 << cmd_col;
                        else
                            bl_d = 8'b1 << cmd_col;
                    end
                end
            end
            ST_SETUP: begin
                if (timer_q == '0) begin
                    state_d = ST_PULSE;
                    case (op_q)
                        OP_FORM:  timer_d = FORM_LD;
                        OP_WRITE: timer_d = WRITE_LD;
                        default:  timer_d = MAC_LD;
                    endcase
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (timer_q == '0) begin
                    state_d = ST_HOLD;
                    timer_d = HOLD_LD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (timer_q == '0) begin
                    state_d = ST_DONE;
                    wl_d    = '0;
                    bl_d    = '0;
                    sl_d    = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
                wl_d    = '0;
                bl_d    = '0;
                sl_d    = '0;
            end
        endcase

        // Outputs are decoded from the next state so they line up with it after the edge.
        form_d = (state_d == ST_PULSE) && (op_d == OP_FORM);
        wen_d  = (state_d == ST_PULSE) && (op_d == OP_WRITE);
        mac_d  = (state_d == ST_PULSE) && (op_d == OP_MAC);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            op_q    <= OP_NOP;
            wl_q    <= '0;
            bl_q    <= '0;
            sl_q    <= '0;
            wen_q   <= 1'b0;
            form_q  <= 1'b0;
            mac_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            op_q    <= op_d;
            wl_q    <= wl_d;
            bl_q    <= bl_d;
            sl_q    <= sl_d;
            wen_q   <= wen_d;
            form_q  <= form_d;
            mac_q   <= mac_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign wordline   = wl_q;
    assign bitline    = bl_q;
    assign selectline = sl_q;
    assign wenable    = wen_q;
    assign form       = form_q;
    assign mac        = mac_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_crossbar_seq.sv
// Directed bench for crossbar_seq with default timing parameters.
// Cycle n is sampled on the falling edge after the (n-1)th rising edge following acceptance.
module tb_crossbar_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_row;
    logic [2:0] cmd_col;
    logic       cmd_data;
    logic [7:0] cmd_x;
    logic [7:0] bitline, wordline, selectline;
    logic       wenable, form, mac, busy, done, err;

    int n_checks = 0;
    int n_fail   = 0;

    int         r_done, r_first, r_form, r_wen, r_mac, r_multi, r_err;
    logic [7:0] r_wl, r_bl, r_sl;
    logic       r_busy1, r_ready_done, r_ready_after, r_busy_after;
    logic [23:0] r_lines_done;

    always #5 clk = ~clk;

    crossbar_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_data   (cmd_data),
        .cmd_x      (cmd_x),
        .bitline    (bitline),
        .wordline   (wordline),
        .selectline (selectline),
        .wenable    (wenable),
        .form       (form),
        .mac        (mac),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one command and records timing/line observations until done (or timeout).
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] row, input logic [2:0] col,
                           input logic d, input logic [7:0] x, input logic hold);
        int waited = 0;
        r_done = -1; r_first = -1; r_form = 0; r_wen = 0; r_mac = 0; r_multi = 0; r_err = 0;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            chk("ready_wait", 32'd0, 32'd1);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = d; cmd_x = x;
        @(posedge clk);
        #1;
        if (hold) begin
            cmd_op = 2'b01; cmd_row = 3'd6; cmd_col = 3'd6;
        end else begin
            cmd_valid = 1'b0;
        end
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == 1) begin
                r_wl = wordline; r_bl = bitline; r_sl = selectline; r_busy1 = busy;
            end
            if ((form || wenable || mac) && r_first < 0) r_first = n;
            r_form += int'(form);
            r_wen  += int'(wenable);
            r_mac  += int'(mac);
            if ((int'(form) + int'(wenable) + int'(mac)) > 1) r_multi++;
            r_err  += int'(err);
            if (done) begin
                r_done       = n;
                r_ready_done = cmd_ready;
                r_lines_done = {wordline, bitline, selectline};
                break;
            end
        end
        cmd_valid = 1'b0;
        if (r_done < 0) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        r_ready_after = cmd_ready;
        r_busy_after  = busy;
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_row = 3'd0; cmd_col = 3'd0;
        cmd_data = 1'b0; cmd_x = 8'h00;
        repeat (3) @(negedge clk);
        chk("ready_in_reset", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_outs", {wordline, bitline, selectline, wenable, form, mac, busy, done, err}, 32'd0);

        // FORM row 3 col 5
        run_cmd(2'b01, 3'd3, 3'd5, 1'b0, 8'h00, 1'b0);
        chk("form_lines_c1", {r_wl, r_bl, r_sl}, {8'h08, 8'h20, 8'h00});
        chk("form_busy_c1", 32'(r_busy1), 32'd1);
        chk("form_first", 32'(r_first), 32'd3);
        chk("form_width", 32'(r_form), 32'd20);
        chk("form_other_stb", 32'(r_wen + r_mac), 32'd0);
        chk("form_done_cyc", 32'(r_done), 32'd25);
        chk("form_lines_done", 32'(r_lines_done), 32'd0);
        chk("form_ready_done", 32'(r_ready_done), 32'd0);
        chk("form_ready_after", {r_ready_after, r_busy_after}, 32'b10);

        // WRITE RESET row 0 col 7
        run_cmd(2'b10, 3'd0, 3'd7, 1'b0, 8'h00, 1'b0);
        chk("wrst_lines_c1", {r_wl, r_bl, r_sl}, {8'h01, 8'h00, 8'h80});
        chk("wrst_first", 32'(r_first), 32'd3);
        chk("wrst_width", 32'(r_wen), 32'd10);
        chk("wrst_other_stb", 32'(r_form + r_mac), 32'd0);
        chk("wrst_done_cyc", 32'(r_done), 32'd15);

        // MAC straight after, with cmd_valid held through busy
        run_cmd(2'b11, 3'd0, 3'd0, 1'b0, 8'hA5, 1'b1);
        chk("mac_lines_c1", {r_wl, r_bl, r_sl}, {8'hFF, 8'hA5, 8'h00});
        chk("mac_first", 32'(r_first), 32'd3);
        chk("mac_width", 32'(r_mac), 32'd4);
        chk("mac_no_form", 32'(r_form + r_wen), 32'd0);
        chk("mac_done_cyc", 32'(r_done), 32'd9);
        chk("mac_multi_stb", 32'(r_multi), 32'd0);
        chk("mac_idle_after", {r_ready_after, r_busy_after}, 32'b10);

`ifdef CROSSBAR_SEQ_FORM_LOCK_EN
        run_cmd(2'b10, 3'd1, 3'd1, 1'b1, 8'h00, 1'b0);
        chk("lock_done_cyc", 32'(r_done), 32'd1);
        chk("lock_err", 32'(r_err), 32'd1);
        chk("lock_no_wen", 32'(r_wen), 32'd0);
        chk("lock_lines", {r_wl, r_bl, r_sl}, 32'd0);
        run_cmd(2'b01, 3'd1, 3'd1, 1'b0, 8'h00, 1'b0);
        chk("lock_form_done", 32'(r_done), 32'd25);
`endif
        // WRITE SET row 1 col 1 (after the optional FORM when locking is built in)
        run_cmd(2'b10, 3'd1, 3'd1, 1'b1, 8'h00, 1'b0);
        chk("wset_lines_c1", {r_wl, r_bl, r_sl}, {8'h02, 8'h02, 8'h00});
        chk("wset_width", 32'(r_wen), 32'd10);
        chk("wset_done_cyc", 32'(r_done), 32'd15);
        chk("wset_err", 32'(r_err), 32'd0);

        // Reset mid-PULSE of a WRITE SET row 2 col 4
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_row = 3'd2; cmd_col = 3'd4; cmd_data = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_pre_wen", {wenable, wordline, bitline}, {1'b1, 8'h04, 8'h10});
        rst = 1'b1;
        #1;
        chk("abort_outs", {wordline, bitline, selectline, wenable, form, mac, busy, done}, 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            done_seen += int'(done);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            done_seen += int'(done) + int'(wenable);
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_ready_after", 32'(cmd_ready), 32'd1);

        run_cmd(2'b00, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0);
        chk("nop_done_cyc", 32'(r_done), 32'd1);
        chk("nop_no_stb", 32'(r_form + r_wen + r_mac), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
